mmio_button_in: RTL and testbench
=================================

// Module: mmio_button_in
// PURPOSE
//  Memory-mapped input peripheral: brings N_BTN asynchronous board buttons/switches into the CPU.
//  Synchronises, debounces and edge-detects each input, and exposes level and sticky-edge registers
//  on the CPU data bus next to the LED MMIO. Inbound counterpart of the LED output register.
// PARAMETERS
//  N_BTN           4               number of input lines (1..32)
//  DEBOUNCE_CYCLES 250000          sys_clk cycles an input must be stable before acceptance (>=2)
//  BASE_ADDR       32'h8000_0010   byte address of register window (word aligned)
// PORTS
//  sys_clk     in   1      clock
//  reset       in   1      synchronous, active-high reset
//  btn_in      in   N_BTN  raw asynchronous button levels (1 = pressed)
//  addr        in   32     CPU byte address (alu_result)
//  mem_write   in   1      CPU store strobe, level, may persist several sys_clk cycles
//  write_data  in   32     CPU store data
//  hit         out  1      combinational: addr inside window [BASE_ADDR, BASE_ADDR+12)
//  read_data   out  32     combinational read data; 0 when hit=0
//  irq         out  1      only with MMIO_BTN_IRQ_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (sys_clk edge, reset=1): sync flops, stable levels, counters, EDGE, IE all 0; irq=0.
//  Sync: 2-flop synchroniser per bit -> sync[i]; 2-cycle input latency.
//  Debounce per bit, independent counter cnt[i] (width clog2(DEBOUNCE_CYCLES)):
//   - sync[i]==stable[i]: cnt[i]<=0.
//   - sync[i]!=stable[i] and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i]<=cnt[i]+1.
//   - sync[i]!=stable[i] and cnt[i]==DEBOUNCE_CYCLES-1: stable[i]<=sync[i], cnt[i]<=0.
//   - any glitch back to stable level restarts count; counter never wraps.
//   - btn_in change to stable[i] update: exactly 2+DEBOUNCE_CYCLES sys_clk edges.
//  Edge detect: rise[i] = stable[i] 0->1 transition (one cycle) -> sets EDGE[i].
//  Register map (offset from BASE_ADDR, word access only, addr[1:0] ignored):
//   0x0 LEVEL  RO  {0, stable[N_BTN-1:0]}; writes ignored
//   0x4 EDGE   W1C sticky rising-edge flags; write 1 clears bit, 0 no effect
//   0x8 IE     RW  irq mask (MMIO_BTN_IRQ_EN only; else reads 0, writes ignored)
//  Unused upper bits read 0. Writes act on every sys_clk edge with mem_write=1 && hit;
//   repeated writes from a held strobe are idempotent (W1C/RW).
//  Simultaneous rise[i] and W1C of bit i in same cycle: set wins, EDGE[i]=1.
//  Release (1->0) never sets EDGE. Reset mid-debounce discards pending change.
//  read_data: pure function of addr and current registers, no read side effects.
// CONFIGURATION
//  MMIO_BTN_IRQ_EN defined: IE register (reset 0) implemented; port irq present,
//   irq registered = |(EDGE & IE), one cycle after EDGE/IE update; clear via W1C of EDGE.
//  MMIO_BTN_IRQ_EN undefined: no irq port, no IE storage; offset 0x8 reads 0.
// TESTING  (DEBOUNCE_CYCLES=8, N_BTN=4, BASE_ADDR=32'h8000_0010)
//  1 reset held, btn_in=4'hF -> read 0x8000_0010 and 0x8000_0014 both 0; release reset,
//    btn_in=4'b0001 steady -> LEVEL=1 exactly 10 edges later, EDGE=1 on the following edge.
//  2 bounce: btn_in[1] toggles every 3 cycles for 30 cycles then stays 1 -> LEVEL[1]
//    stays 0 during bouncing, goes 1 exactly 10 edges after final toggle; EDGE=4'b0010.
//  3 W1C: EDGE=4'b0011, store 32'h1 to 0x8000_0014 held 4 cycles -> EDGE=4'b0010;
//    store 0 -> unchanged; read 0x8000_0020 -> hit=0, read_data=0.
//  4 collision: W1C bit 2 on same edge rise[2] fires -> EDGE[2]=1 afterwards.
//  5 release: btn_in[0] 1->0 debounced -> LEVEL[0]=0, EDGE unchanged; reset asserted
//    at cnt=5 of a pending press -> no LEVEL/EDGE change after reset.
//  6 MMIO_BTN_IRQ_EN: IE=4'b0100, press btn 2 -> irq=1 one cycle after EDGE[2]; press
//    btn 0 -> irq unchanged; W1C bit 2 -> irq=0 next cycle.

Source files
------------

// File: rtl/mmio_button_in.sv
//==============================================================================
// Module   : mmio_button_in
// Synchronised, debounced, rising-edge-latching button input register window.
// Optional MMIO_BTN_IRQ_EN adds an IE mask register and a registered irq output.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mmio_button_in #(
    parameter int          N_BTN           = 4,
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter logic [31:0] BASE_ADDR       = 32'h8000_0010
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [31:0]      addr,
    input  logic             mem_write,
    input  logic [31:0]      write_data,
    output logic             hit,
    output logic [31:0]      read_data
`ifdef MMIO_BTN_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync_q, sync_d;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] stable_dly_q, stable_dly_d;
    logic [N_BTN-1:0] edge_q, edge_d;

    logic [31:0]      w_offset;
    logic [1:0]       w_reg_sel;
    logic             w_wr;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_edge_clr;

    assign hit       = (addr >= BASE_ADDR) && (addr < (BASE_ADDR + 32'd12));
    assign w_offset  = addr - BASE_ADDR;
    assign w_reg_sel = w_offset[3:2];
    assign w_wr      = mem_write && hit;

    assign w_rise     = stable_q & ~stable_dly_q;
    assign w_edge_clr = (w_wr && (w_reg_sel == 2'd1)) ? write_data[N_BTN-1:0] : '0;

    // Per-line debounce: the stable level only follows sync after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreement restarts the count.
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [c_cnt_w-1:0] cnt_q, cnt_d;
        logic               stable_nxt;

        always_comb begin
            cnt_d      = '0;
            stable_nxt = stable_q[i];
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q == c_cnt_max) begin
                    stable_nxt = sync_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge sys_clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign stable_d[i] = stable_nxt;
    end

    always_comb begin
        sync1_d      = btn_in;
        sync_d       = sync1_q;
        stable_dly_d = stable_q;
        // A rise landing on the same edge as its W1C must survive.
        edge_d       = (edge_q & ~w_edge_clr) | w_rise;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sync1_q      <= '0;
            sync_q       <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            edge_q       <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync_q       <= sync_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            edge_q       <= edge_d;
        end
    end

`ifdef MMIO_BTN_IRQ_EN
    logic [N_BTN-1:0] ie_q, ie_d;
    logic             irq_q, irq_d;

    always_comb begin
        ie_d  = (w_wr && (w_reg_sel == 2'd2)) ? write_data[N_BTN-1:0] : ie_q;
        irq_d = |(edge_q & ie_q);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            ie_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        read_data = '0;
        if (hit) begin
            case (w_reg_sel)
                2'd0:    read_data = 32'(stable_q);
                2'd1:    read_data = 32'(edge_q);
`ifdef MMIO_BTN_IRQ_EN
                2'd2:    read_data = 32'(ie_q);
`endif
                default: read_data = '0;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, w_offset, write_data};

endmodule

`default_nettype wire

// File: tb/tb_mmio_button_in.sv
//==============================================================================
// Module   : tb_mmio_button_in
// Directed scoreboard bench for mmio_button_in (DEBOUNCE_CYCLES=8, N_BTN=4).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_mmio_button_in;

    localparam logic [31:0] c_lvl = 32'h8000_0010;
    localparam logic [31:0] c_edg = 32'h8000_0014;
    localparam logic [31:0] c_ie  = 32'h8000_0018;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic [3:0]  btn_in;
    logic [31:0] addr;
    logic        mem_write;
    logic [31:0] write_data;
    logic        hit;
    logic [31:0] read_data;
    logic        act_irq;
`ifdef MMIO_BTN_IRQ_EN
    logic        irq;
    assign act_irq = irq;
`else
    assign act_irq = 1'b0;
`endif

    logic rd_strobe = 1'b0;

    typedef struct {
        string       nm;
        logic        eh;
        logic [31:0] ed;
        logic        ei;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mmio_button_in #(
        .N_BTN          (4),
        .DEBOUNCE_CYCLES(8),
        .BASE_ADDR      (32'h8000_0010)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .addr      (addr),
        .mem_write (mem_write),
        .write_data(write_data),
        .hit       (hit),
        .read_data (read_data)
`ifdef MMIO_BTN_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Monitor: every presented read pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge rd_strobe);
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL no_expectation: hit=%0b data=%h with empty scoreboard", hit, read_data);
            end else begin
                e = sb.pop_front();
                if (hit === e.eh && read_data === e.ed && act_irq === e.ei) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got hit=%0b data=%h irq=%0b, expected hit=%0b data=%h irq=%0b",
                             e.nm, hit, read_data, act_irq, e.eh, e.ed, e.ei);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic eh,
                      input logic [31:0] ed, input logic ei = 1'b0);
        addr = a;
        sb.push_back('{nm, eh, ed, ei});
        #1 rd_strobe = 1'b1;
        #1 rd_strobe = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int n);
        addr       = a;
        write_data = d;
        mem_write  = 1'b1;
        repeat (n) tick();
        mem_write  = 1'b0;
        write_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        btn_in     = 4'hF;
        addr       = '0;
        mem_write  = 1'b0;
        write_data = '0;

        // Reset with all buttons pressed: nothing visible.
        repeat (3) tick();
        rd("rst_level", c_lvl, 1'b1, 32'h0);
        rd("rst_edge",  c_edg, 1'b1, 32'h0);

        // Single press: LEVEL after 10 edges, EDGE one edge later.
        reset  = 1'b0;
        btn_in = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            rd($sformatf("t1_level_k%0d", k), c_lvl, 1'b1, (k >= 10) ? 32'h1 : 32'h0);
            rd($sformatf("t1_edge_k%0d", k),  c_edg, 1'b1, (k >= 11) ? 32'h1 : 32'h0);
        end

        // Bounce on btn 1: ten toggles 3 cycles apart, then held high.
        for (int j = 0; j < 10; j++) begin
            btn_in[1] = ~btn_in[1];
            for (int c = 0; c < 3; c++) begin
                tick();
                rd($sformatf("t2_bounce_j%0d_c%0d", j, c), c_lvl, 1'b1, 32'h1);
            end
        end
        btn_in[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            rd($sformatf("t2_level_k%0d", k), c_lvl, 1'b1, (k >= 10) ? 32'h3 : 32'h1);
            rd($sformatf("t2_edge_k%0d", k),  c_edg, 1'b1, (k >= 11) ? 32'h3 : 32'h1);
        end

        // W1C with a held strobe, zero write, out-of-window and aliased reads.
        wr(c_edg, 32'h1, 4);
        rd("t3_edge_w1c", c_edg, 1'b1, 32'h2);
        wr(c_edg, 32'h0, 2);
        rd("t3_edge_w0", c_edg, 1'b1, 32'h2);
        rd("t3_miss_hi", 32'h8000_0020, 1'b0, 32'h0);
        rd("t3_miss_lo", 32'h8000_000C, 1'b0, 32'h0);
        rd("t3_last_oob", 32'h8000_001C, 1'b0, 32'h0);
        rd("t3_level_alias", 32'h8000_0013, 1'b1, 32'h3);
        wr(c_lvl, 32'hFFFF_FFFF, 1);
        rd("t3_level_ro", c_lvl, 1'b1, 32'h3);
        rd("t3_ie_reset", c_ie, 1'b1, 32'h0);

        // Collision: W1C of bit 2 on the edge where rise[2] sets it.
        btn_in[2] = 1'b1;
        repeat (10) tick();
        wr(c_edg, 32'h4, 1);
        rd("t4_edge_collide", c_edg, 1'b1, 32'h6);
        rd("t4_level", c_lvl, 1'b1, 32'h7);

        // Release never sets EDGE.
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            rd($sformatf("t5_rel_level_k%0d", k), c_lvl, 1'b1, (k >= 10) ? 32'h6 : 32'h7);
        end
        rd("t5_rel_edge", c_edg, 1'b1, 32'h6);

        // Reset while btn 3 is five counts into its debounce.
        btn_in[3] = 1'b1;
        repeat (7) tick();
        reset  = 1'b1;
        btn_in = 4'h0;
        repeat (2) tick();
        reset = 1'b0;
        for (int k = 0; k <= 12; k += 4) begin
            rd($sformatf("t5_rst_level_k%0d", k), c_lvl, 1'b1, 32'h0);
            rd($sformatf("t5_rst_edge_k%0d", k),  c_edg, 1'b1, 32'h0);
            repeat (4) tick();
        end

`ifdef MMIO_BTN_IRQ_EN
        wr(c_ie, 32'h4, 1);
        rd("t6_ie", c_ie, 1'b1, 32'h4);
        btn_in = 4'b0100;
        for (int k = 1; k <= 13; k++) begin
            tick();
            rd($sformatf("t6_b2_k%0d", k), c_edg, 1'b1, (k >= 11) ? 32'h4 : 32'h0, (k >= 12));
        end
        btn_in = 4'b0101;
        for (int k = 1; k <= 12; k++) begin
            tick();
            rd($sformatf("t6_b0_k%0d", k), c_edg, 1'b1, (k >= 11) ? 32'h5 : 32'h4, 1'b1);
        end
        wr(c_edg, 32'h4, 1);
        rd("t6_clr_same", c_edg, 1'b1, 32'h1, 1'b1);
        tick();
        rd("t6_clr_next", c_edg, 1'b1, 32'h1, 1'b0);
`else
        wr(c_ie, 32'hF, 1);
        rd("t6_ie_absent", c_ie, 1'b1, 32'h0);
`endif

        tick();
        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
